// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pipebuf.sv
// gf180mcu_fd_sc_mcu9t5v0_pipebuf: elastic in-order valid/ready buffer of DEPTH words x WIDTH bits.
// Optional macro GF180_PIPEBUF_BYPASS_EN adds a zero-latency I->Z path while the buffer is empty.
module gf180mcu_fd_sc_mcu9t5v0_pipebuf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [WIDTH-1:0] Z,
   output logic             Z_VALID,
   input  logic             Z_READY,
   output logic [LW-1:0]    LEVEL,
   inout  wire              VDD,
   inout  wire              VSS
);
   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_nonempty;
   logic             w_push;
   logic             w_pop;
   logic             w_store;

   // Supply pins carry no logic; tie them off into a named sink.
   wire w_unused_pwr = VDD ^ VSS;

   assign w_nonempty = (r_level != '0);
   assign I_READY    = RN & (r_level < FULL);
   assign w_push     = I_VALID & I_READY;
   assign w_pop      = w_nonempty & Z_READY;
   assign LEVEL      = r_level;

`ifdef GF180_PIPEBUF_BYPASS_EN
   logic w_bypass;
   // An empty buffer forwards I directly; only a stalled consumer forces a store.
   assign w_bypass = ~w_nonempty & I_VALID & RN;
   assign w_store  = w_push & ~(w_bypass & Z_READY);
   assign Z_VALID  = w_nonempty | w_bypass;
   assign Z        = w_nonempty ? r_mem[r_rd_ptr] : (w_bypass ? I : '0);
`else
   assign w_store  = w_push;
   assign Z_VALID  = w_nonempty;
   assign Z        = w_nonempty ? r_mem[r_rd_ptr] : '0;
`endif

   always_ff @(posedge CLK) begin
      if (w_store) r_mem[r_wr_ptr] <= I;
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_level  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_store) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         case ({w_store, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_pipebuf.sv
// Bench: DEPTH=1,2,3 instances on shared stimulus, each checked every cycle against a queue model.
module tb_gf180mcu_fd_sc_mcu9t5v0_pipebuf;
   localparam int ND = 3;
`ifdef GF180_PIPEBUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rn  = 1'b0;
   logic       iv  = 1'b0;
   logic       zr  = 1'b0;
   logic [7:0] din = 8'h00;
   logic       started = 1'b0;
   wire        vdd = 1'b1;
   wire        vss = 1'b0;

   logic [31:0] lvl_a  [ND];
   logic [7:0]  z_a    [ND];
   logic        zv_a   [ND];
   logic        irdy_a [ND];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < ND; g++) begin : gi
      localparam int D = g + 1;
      localparam int L = $clog2(D + 1);
      logic [L-1:0] lvl;
      int           q[$];

      gf180mcu_fd_sc_mcu9t5v0_pipebuf #(.WIDTH(8), .DEPTH(D)) dut (
         .CLK(clk), .RN(rn), .I(din), .I_VALID(iv), .I_READY(irdy_a[g]),
         .Z(z_a[g]), .Z_VALID(zv_a[g]), .Z_READY(zr), .LEVEL(lvl),
         .VDD(vdd), .VSS(vss));

      assign lvl_a[g] = 32'(lvl);

      // Reference: a plain queue of at most D words.
      always @(posedge clk) begin
         bit pu, po;
         if (!rn) q.delete();
         else begin
            pu = iv && (q.size() < D);
            po = (q.size() != 0) && zr;
            if (BYP && q.size() == 0 && iv && zr) pu = 1'b0;
            if (po) void'(q.pop_front());
            if (pu) q.push_back(int'(din));
         end
      end

      always @(negedge clk) if (started) begin
         int el, ez, er;
         bit ev;
         el = q.size();
         ev = (el != 0);
         ez = ev ? q[0] : 0;
         er = (rn && el < D) ? 1 : 0;
         if (BYP && !ev && iv && rn) begin
            ev = 1'b1;
            ez = int'(din);
         end
         chk($sformatf("d%0d_level", D), lvl_a[g], el);
         chk($sformatf("d%0d_zvalid", D), 32'(zv_a[g]), 32'(ev));
         chk($sformatf("d%0d_z", D), 32'(z_a[g]), ez);
         chk($sformatf("d%0d_iready", D), 32'(irdy_a[g]), er);
      end
   end

   task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic c);
      rn = r; iv = v; din = d; zr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two edges with a push pending
      drive(1'b0, 1'b1, 8'hA5, 1'b0);
      started = 1'b1;
      drive(1'b0, 1'b1, 8'hA5, 1'b0);
      chk("rst_level", lvl_a[1], 0);
      chk("rst_zvalid", 32'(zv_a[1]), 0);
      chk("rst_z", 32'(z_a[1]), 0);
      chk("rst_iready", 32'(irdy_a[1]), 0);
      rn = 1'b1; iv = 1'b0;
      #1;
      chk("rel_iready", 32'(irdy_a[1]), 1);

      // Fill and drain DEPTH=2
      drive(1'b1, 1'b1, 8'h11, 1'b0);
      chk("fill1_level", lvl_a[1], 1);
      drive(1'b1, 1'b1, 8'h22, 1'b0);
      chk("fill2_level", lvl_a[1], 2);
      chk("fill2_iready", 32'(irdy_a[1]), 0);
      chk("fill2_z", 32'(z_a[1]), 32'h11);
      drive(1'b1, 1'b1, 8'h33, 1'b0);
      chk("refuse_level", lvl_a[1], 2);
      chk("refuse_z", 32'(z_a[1]), 32'h11);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      chk("drain1_level", lvl_a[1], 1);
      chk("drain1_z", 32'(z_a[1]), 32'h22);
      chk("drain1_iready", 32'(irdy_a[1]), 1);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      chk("drain2_level", lvl_a[1], 0);
      chk("drain2_zvalid", 32'(zv_a[1]), 0);

      // Streaming through DEPTH=3
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 8'(i), 1'b1);
         chk($sformatf("stream_z%0d", i), 32'(z_a[2]), i);
         chk($sformatf("stream_lvl%0d", i), lvl_a[2], BYP ? 0 : 1);
      end
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      chk("stream_end_level", lvl_a[2], 0);

      // Reset while full, with a push and pop offered at the same edge
      drive(1'b1, 1'b1, 8'hA1, 1'b0);
      drive(1'b1, 1'b1, 8'hA2, 1'b0);
      chk("mid_pre_level", lvl_a[1], 2);
      drive(1'b0, 1'b1, 8'hA3, 1'b1);
      chk("mid_level", lvl_a[1], 0);
      chk("mid_zvalid", 32'(zv_a[1]), 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'h00, 1'b1);
         chk($sformatf("mid_stale_zv%0d", i), 32'(zv_a[1]), 0);
         chk($sformatf("mid_stale_z%0d", i), 32'(z_a[1]), 0);
      end

`ifdef GF180_PIPEBUF_BYPASS_EN
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      rn = 1'b1; iv = 1'b1; din = 8'h5A; zr = 1'b1;
      #1;
      chk("byp_z", 32'(z_a[1]), 32'h5A);
      chk("byp_zvalid", 32'(zv_a[1]), 1);
      @(posedge clk); #1;
      chk("byp_level", lvl_a[1], 0);
      zr = 1'b0;
      @(posedge clk); #1;
      chk("byp_store_level", lvl_a[1], 1);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
`endif

      // Random traffic with occasional reset, phases biased toward fill or drain
      for (int i = 0; i < 1000; i++) begin
         int pv, pr;
         pv = (i / 100) % 2 == 0 ? 70 : 35;
         pr = (i / 100) % 2 == 0 ? 35 : 70;
         drive(($urandom_range(99) != 0), ($urandom_range(99) < pv),
               8'($urandom), ($urandom_range(99) < pr));
      end
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      started = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
